alu_cmd_issue: RTL
==================

ALU_CMD_ISSUE -- requirements
Module: alu_cmd_issue

Interface
REQ-001 Parameter DATA_ALU, 32, operand and result width.
REQ-002 Parameter OP_SZ, 3, ALU opcode width.
REQ-003 Parameter SH_SZ, 5, shift-amount width.
REQ-004 Parameter DEPTH, 4, command FIFO entries; power of two, at least 2.
REQ-005 I_CLK  in  1  sole clock; all state updates on rising edge.
REQ-006 I_RST_N  in  1  asynchronous, active-low reset.
REQ-007 I_VLD  in  1  upstream command valid.
REQ-008 O_RDY  out  1  command accepted when I_VLD and O_RDY are both 1 at a rising edge.
REQ-009 I_OP / I_A / I_B / I_SH  in  OP_SZ / DATA_ALU / DATA_ALU / SH_SZ  command fields.
REQ-010 O_ALU_OP / O_ALU_A / O_ALU_B / O_ALU_SH  out  OP_SZ / DATA_ALU / DATA_ALU / SH_SZ  drive the downstream ALU inputs.
REQ-011 I_ALU_RSL  in  DATA_ALU  combinational result returned by the ALU.
REQ-012 O_VLD  out  1  registered result valid.
REQ-013 I_RDY  in  1  result consumed when O_VLD and I_RDY are both 1 at a rising edge.
REQ-014 O_RSL  out  DATA_ALU  registered ALU result.
REQ-015 O_OVF  out  1  signed-overflow flag aligned with O_RSL.
REQ-016 O_CNT  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 Commands shall be stored in a DEPTH-entry FIFO using read and write pointers one bit wider than the address; full when the addresses match and the MSBs differ, empty when the pointers are equal.
REQ-018 O_RDY shall equal not-full; a push while full shall not occur, and the FIFO provides no bypass when full, even if a pop happens in the same cycle.
REQ-019 O_ALU_* shall be driven combinationally from the FIFO head entry, and shall be all-zero when the FIFO is empty.
REQ-020 Issue condition: FIFO not empty AND (O_VLD==0 OR I_RDY==1); on issue the head shall be popped and I_ALU_RSL registered into O_RSL with O_VLD set to 1 at the same edge.
REQ-021 If a result is consumed and nothing is issued in the same cycle, O_VLD shall clear to 0 at that edge.
REQ-022 While O_VLD==1 and I_RDY==0, O_RSL, O_OVF and O_VLD shall hold stable, and the FIFO shall not pop.
REQ-023 Latency: a command accepted at edge k shall produce O_VLD=1 after edge k+1 when the output is free; sustained throughput is one result per cycle.
REQ-024 A push and a pop in the same cycle shall leave O_CNT unchanged; O_CNT shall otherwise increment on a push and decrement on a pop.
REQ-025 Empty-FIFO push: the entry becomes head after the edge; no issue occurs in the push cycle.
REQ-026 The opcode shall be passed unmodified; undefined opcodes get no special handling.
REQ-027 Commands shall be issued in strict arrival order; no command shall be dropped or duplicated.

Reset
REQ-028 While I_RST_N==0, pointers and O_CNT shall be 0, O_VLD=0, O_RSL=0, O_OVF=0, and O_RDY shall be 1 (O_RDY is 1 in reset because the FIFO is empty).
REQ-029 Reset asserted mid-operation shall discard all queued commands and any pending result immediately, without waiting for a clock edge.

Configuration
REQ-030 With macro ALU_OVF_CHECK_EN defined, O_OVF shall be registered on issue: for op 000 (ADD), it is 1 when A and B have equal sign bits and the sum's sign differs; for op 110 (SUB), it is 1 when A and B signs differ and the difference's sign differs from A's sign; for all other ops it is 0.
REQ-031 Without ALU_OVF_CHECK_EN, O_OVF shall be constant 0 and no overflow logic shall be synthesized.

Verification
REQ-032 Reset, then push ADD A=5 B=7 with I_RDY=1 -> O_VLD rises after 2 edges, O_RSL=12, O_OVF=0, O_CNT returns to 0.
REQ-033 Hold I_RDY=0 and push 5 commands -> O_RDY=0 once O_CNT=4, with one result held stable in O_RSL; raise I_RDY -> all 5 results emerge in order with no gaps.
REQ-034 ALU_OVF_CHECK_EN defined: ADD A=0x7FFFFFFF B=1 -> O_RSL=0x80000000, O_OVF=1; SUB A=0x80000000 B=1 -> O_OVF=1; ADDU with the same operands -> O_OVF=0.
REQ-035 Continuous I_VLD with I_RDY=1 and 8 commands (ops SLL SH=4 A=1, SRA SH=1 A=0xFFFFFFF0, ...) -> one result per cycle, O_CNT never exceeds 1, expected values 0x10 and 0xFFFFFFF8.
REQ-036 Assert I_RST_N=0 with O_CNT=3 and O_VLD=1 -> O_VLD, O_CNT and O_RSL go to 0 immediately (asynchronously) and O_RDY=1; the first command after release returns the correct result.
REQ-037 Toggle I_RDY randomly while pushing 32 commands at a 50% rate -> the output sequence matches a software ALU model, with no loss and no reordering.

Source files
------------

// File: rtl/alu_cmd_issue.sv
// ---------------------------------------------------------------------------
// alu_cmd_issue
//
// Purpose:
//   Buffers ALU commands in a small FIFO. The head entry drives an external
//   combinational ALU, and the ALU result is captured into an output register
//   with a valid/ready handshake. Commands issue in strict arrival order.
//   When the output register is free, throughput is one result per cycle.
//
// Ports:
//   I_CLK, I_RST_N        clock; asynchronous active-low reset
//   I_VLD / O_RDY         command handshake (O_RDY = FIFO not full)
//   I_OP, I_A, I_B, I_SH  command fields
//   O_ALU_OP/A/B/SH       FIFO head fields to the ALU (all zero when empty)
//   I_ALU_RSL             combinational result returned by the ALU
//   O_VLD / I_RDY         result handshake
//   O_RSL, O_OVF          registered result and signed-overflow flag
//   O_CNT                 FIFO occupancy
//
// Configuration:
//   ALU_OVF_CHECK_EN      When defined, O_OVF is registered on issue for
//                         ADD (000) and SUB (110). When undefined, O_OVF
//                         is tied to 0.
// ---------------------------------------------------------------------------
module alu_cmd_issue #(
    parameter int DATA_ALU = 32,
    parameter int OP_SZ    = 3,
    parameter int SH_SZ    = 5,
    parameter int DEPTH    = 4
) (
    input  logic                      I_CLK,
    input  logic                      I_RST_N,
    input  logic                      I_VLD,
    output logic                      O_RDY,
    input  logic [OP_SZ-1:0]          I_OP,
    input  logic [DATA_ALU-1:0]       I_A,
    input  logic [DATA_ALU-1:0]       I_B,
    input  logic [SH_SZ-1:0]          I_SH,
    output logic [OP_SZ-1:0]          O_ALU_OP,
    output logic [DATA_ALU-1:0]       O_ALU_A,
    output logic [DATA_ALU-1:0]       O_ALU_B,
    output logic [SH_SZ-1:0]          O_ALU_SH,
    input  logic [DATA_ALU-1:0]       I_ALU_RSL,
    output logic                      O_VLD,
    input  logic                      I_RDY,
    output logic [DATA_ALU-1:0]       O_RSL,
    output logic                      O_OVF,
    output logic [$clog2(DEPTH):0]    O_CNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Command storage. The pointers are one bit wider than the address.
    logic [OP_SZ-1:0]    op_mem_q [DEPTH];
    logic [DATA_ALU-1:0] a_mem_q  [DEPTH];
    logic [DATA_ALU-1:0] b_mem_q  [DEPTH];
    logic [SH_SZ-1:0]    sh_mem_q [DEPTH];

    logic [CW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                rdy_q, rdy_d;
    logic                vld_q, vld_d;
    logic [DATA_ALU-1:0] rsl_q, rsl_d;

    logic                full_s;
    logic                empty_s;
    logic                push_s;
    logic                pop_s;

    // FIFO status decoded from the current pointers.
    always_comb begin
        full_s  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        empty_s = (wr_ptr_q == rd_ptr_q);
    end

    // Handshake decode. A push is allowed only when not full, with no
    // bypass. A pop happens only when the output register is free or
    // is being drained in this cycle.
    always_comb begin
        push_s = I_VLD && rdy_q;
        pop_s  = !empty_s && (!vld_q || I_RDY);
    end

    // Drive the ALU from the head entry, and force zeros when the FIFO
    // is empty.
    always_comb begin
        if (empty_s) begin
            O_ALU_OP = {OP_SZ{1'b0}};
            O_ALU_A  = {DATA_ALU{1'b0}};
            O_ALU_B  = {DATA_ALU{1'b0}};
            O_ALU_SH = {SH_SZ{1'b0}};
        end else begin
            O_ALU_OP = op_mem_q[rd_ptr_q[AW-1:0]];
            O_ALU_A  = a_mem_q[rd_ptr_q[AW-1:0]];
            O_ALU_B  = b_mem_q[rd_ptr_q[AW-1:0]];
            O_ALU_SH = sh_mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    // Next state for the pointers and the occupancy count.
    always_comb begin
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + PTR_ONE;
            2'b01:   cnt_d = cnt_q - PTR_ONE;
            default: cnt_d = cnt_q;
        endcase
        // O_RDY is registered as "not full" on the next pointers, so it
        // always matches the pointer-based full condition.
        rdy_d = !((wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]));
    end

    // Next state for the output register. An issue reloads the register.
    // A consume with no issue clears the valid bit. Otherwise the
    // register holds.
    always_comb begin
        if (pop_s) begin
            vld_d = 1'b1;
            rsl_d = I_ALU_RSL;
        end else if (I_RDY) begin
            vld_d = 1'b0;
            rsl_d = rsl_q;
        end else begin
            vld_d = vld_q;
            rsl_d = rsl_q;
        end
    end

    // Command storage write port.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                op_mem_q[i] <= {OP_SZ{1'b0}};
                a_mem_q[i]  <= {DATA_ALU{1'b0}};
                b_mem_q[i]  <= {DATA_ALU{1'b0}};
                sh_mem_q[i] <= {SH_SZ{1'b0}};
            end
        end else if (push_s) begin
            op_mem_q[wr_ptr_q[AW-1:0]] <= I_OP;
            a_mem_q[wr_ptr_q[AW-1:0]]  <= I_A;
            b_mem_q[wr_ptr_q[AW-1:0]]  <= I_B;
            sh_mem_q[wr_ptr_q[AW-1:0]] <= I_SH;
        end
    end

    // Control and result state registers.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            wr_ptr_q <= {CW{1'b0}};
            rd_ptr_q <= {CW{1'b0}};
            cnt_q    <= {CW{1'b0}};
            rdy_q    <= 1'b1;
            vld_q    <= 1'b0;
            rsl_q    <= {DATA_ALU{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rdy_q    <= rdy_d;
            vld_q    <= vld_d;
            rsl_q    <= rsl_d;
        end
    end

    assign O_RDY = rdy_q;
    assign O_VLD = vld_q;
    assign O_RSL = rsl_q;
    assign O_CNT = cnt_q;

`ifdef ALU_OVF_CHECK_EN
    localparam logic [OP_SZ-1:0] OP_ADD = OP_SZ'(0);
    localparam logic [OP_SZ-1:0] OP_SUB = OP_SZ'(6);

    logic ovf_q, ovf_d;

    // Signed overflow, computed from the sign bits of the operands and
    // of the result.
    function automatic logic ovf_calc(input logic [OP_SZ-1:0] op,
                                      input logic a_s, input logic b_s,
                                      input logic r_s);
        logic res;
        case (op)
            OP_ADD:  res = (a_s == b_s) && (r_s != a_s);
            OP_SUB:  res = (a_s != b_s) && (r_s != a_s);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Overflow next state. It is captured alongside the result on issue.
    always_comb begin
        if (pop_s) begin
            ovf_d = ovf_calc(O_ALU_OP, O_ALU_A[DATA_ALU-1], O_ALU_B[DATA_ALU-1],
                             I_ALU_RSL[DATA_ALU-1]);
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow flag register.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign O_OVF = ovf_q;
`else
    assign O_OVF = 1'b0;
`endif

endmodule
